rf_sp_fifo_ctrl: RTL and testbench

// - Initiator-side controller for a single-port register file (1 access/cycle, registered read data,

---
 rtl/rf_sp_fifo_ctrl_if.sv | 29 ++
 rtl/rf_sp_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_rf_sp_fifo_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_sp_fifo_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_sp_fifo_ctrl_if
// Brief    : Write-stream and read-stream handshake bundle for rf_sp_fifo_ctrl.
// Revision : 1.0
// ============================================================================
interface rf_sp_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  // slave = the FIFO controller, master = the producer/consumer side
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface
`default_nettype wire

// File: rtl/rf_sp_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_sp_fifo_ctrl
// Brief    : Streaming FIFO built on a single-port register file with a
//            2-entry output buffer absorbing the 1-cycle read latency.
// Revision : 1.0
// ============================================================================
module rf_sp_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  rf_sp_fifo_ctrl_if.slave           stream,
  output logic [ADDR_WIDTH:0]        count,
  output logic                       rf_enable,
  output logic                       rf_wr,
  output logic [ADDR_WIDTH-1:0]      rf_write_addr,
  output logic [DATA_WIDTH-1:0]      rf_write_data,
  output logic [ADDR_WIDTH-1:0]      rf_read_addr,
  input  wire logic [DATA_WIDTH-1:0] rf_read_data
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  grant_e                r_last_grant;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_inflight;

  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_buf_head;
  logic                  r_buf_tail;
  logic [1:0]            r_buf_occ;

  logic w_can_wr;
  logic w_can_rd;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_push;
  logic w_pop;

  // Credit uses occupancy before this cycle's pop, so the buffer can never overflow.
  assign w_can_wr = (r_count != c_DEPTH);
  assign w_can_rd = (r_count != '0) && (({1'b0, r_inflight} + r_buf_occ) < 2'd2);

  // Grants are masked during reset so the port is quiet the moment reset_n drops.
  assign w_grant_wr = reset_n && stream.s_valid && w_can_wr &&
                      (!w_can_rd || (r_last_grant == GRANT_READ));
  assign w_grant_rd = reset_n && !w_grant_wr && w_can_rd;

  assign stream.s_ready = reset_n && w_can_wr && !(w_can_rd && (r_last_grant == GRANT_WRITE));

  assign rf_enable     = w_grant_wr || w_grant_rd;
  assign rf_wr         = w_grant_wr;
  assign rf_write_addr = r_wr_ptr;
  assign rf_write_data = stream.s_data;
  assign rf_read_addr  = r_rd_ptr;
  assign count         = r_count;

  assign w_push = r_inflight;
  assign w_pop  = (r_buf_occ != 2'd0) && stream.m_ready;

  assign stream.m_valid = (r_buf_occ != 2'd0);
  assign stream.m_data  = r_buf[r_buf_head];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_inflight   <= 1'b0;
      r_last_grant <= GRANT_READ;
    end else begin
      r_inflight <= w_grant_rd;
      if (w_grant_wr) begin
        r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(1);
        r_count      <= r_count + (ADDR_WIDTH + 1)'(1);
        r_last_grant <= GRANT_WRITE;
      end else if (w_grant_rd) begin
        r_rd_ptr     <= r_rd_ptr + ADDR_WIDTH'(1);
        r_count      <= r_count - (ADDR_WIDTH + 1)'(1);
        r_last_grant <= GRANT_READ;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_buf_head <= 1'b0;
      r_buf_tail <= 1'b0;
      r_buf_occ  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_buf_tail] <= rf_read_data;
        r_buf_tail        <= ~r_buf_tail;
      end
      if (w_pop) begin
        r_buf_head <= ~r_buf_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_buf_occ <= r_buf_occ + 2'd1;
        2'b01:   r_buf_occ <= r_buf_occ - 2'd1;
        default: r_buf_occ <= r_buf_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_sp_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rf_sp_fifo_ctrl
// Brief    : Directed, table-driven bench for rf_sp_fifo_ctrl with a behavioural
//            register-file model and an ordering scoreboard.
// Revision : 1.0
// ============================================================================
module tb_rf_sp_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rf_sp_fifo_ctrl_if #(.DATA_WIDTH(DW)) u_if ();

  logic [AW:0]   count;
  logic          rf_enable;
  logic          rf_wr;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data;

  rf_sp_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stream        (u_if),
    .count         (count),
    .rf_enable     (rf_enable),
    .rf_wr         (rf_wr),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data)
  );

  // Single-port register file: registered read data, held when not reading
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q = '0;
  always @(posedge clk) begin
    if (rf_enable) begin
      if (rf_wr) mem[rf_write_addr] <= rf_write_data;
      else       rd_q <= mem[rf_read_addr];
    end
  end
  assign rf_read_data = rd_q;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] sb_q[$];
  logic [AW-1:0] exp_wp;
  logic [DW-1:0] last_pop;
  int            n_acc;
  int            n_rd;
  logic [AW-1:0] acc_addr [8];

  typedef struct {
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    logic          en;
    logic          wr;
    logic          srdy;
    logic          mv;
    logic [DW-1:0] md;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Drive one cycle's inputs, then observe the port and the streams mid-cycle
  task automatic step(input logic sv, input logic [DW-1:0] d, input logic mr);
    @(negedge clk);
    u_if.s_valid = sv;
    u_if.s_data  = d;
    u_if.m_ready = mr;
    #1;
    if (rf_enable && !rf_wr) n_rd++;
    if (sv && u_if.s_ready) begin
      chk("wr_port", {rf_enable, rf_wr, rf_write_addr, rf_write_data}, {2'b11, exp_wp, d});
      acc_addr[n_acc % 8] = rf_write_addr;
      n_acc++;
      sb_q.push_back(d);
      exp_wp = exp_wp + 1'b1;
    end
    if (u_if.m_valid && mr) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got %0h, required no data", u_if.m_data);
      end else begin
        chk("pop_order", u_if.m_data, sb_q.pop_front());
      end
      last_pop = u_if.m_data;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, '0, 1'b1);
    chk("drain_q", sb_q.size(), 0);
    chk("drain_cnt", count, 0);
  endtask

  task automatic fill5(input logic [DW-1:0] base);
    n_acc = 0;
    n_rd  = 0;
    for (int g = 0; g < 20; g++) begin
      if (n_acc < 5) step(1'b1, 8'(base + n_acc), 1'b0);
      else           step(1'b0, '0, 1'b0);
    end
    chk("hold_acc", n_acc, 5);
    chk("hold_reads", n_rd, 2);
    chk("hold_cnt", count, 3);
    chk("hold_mv", u_if.m_valid, 1);
    chk("hold_md", u_if.m_data, base);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    u_if.s_valid = 1'b1;
    u_if.s_data  = 8'hEE;
    u_if.m_ready = 1'b1;
    exp_wp       = '0;
    last_pop     = '0;
    n_acc        = 0;
    n_rd         = 0;

    @(negedge clk);
    #1;
    chk("rst_mv", u_if.m_valid, 0);
    chk("rst_md", u_if.m_data, 0);
    chk("rst_cnt", count, 0);
    chk("rst_en", rf_enable, 0);
    chk("rst_wr", rf_wr, 0);
    @(negedge clk);
    reset_n      = 1'b1;
    u_if.s_valid = 1'b0;

    // Three writes held off the output, then drained; then a lone-write latency run
    //         sv    d      mr    en    wr    srdy  mv    md     cnt
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1};
    tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1};
    tbl[4]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 3'd0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 3'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 3'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[11] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].sv, tbl[i].d, tbl[i].mr);
      chk($sformatf("v%0d_en", i), rf_enable, tbl[i].en);
      chk($sformatf("v%0d_wr", i), rf_wr, tbl[i].wr);
      chk($sformatf("v%0d_srdy", i), u_if.s_ready, tbl[i].srdy);
      chk($sformatf("v%0d_mv", i), u_if.m_valid, tbl[i].mv);
      chk($sformatf("v%0d_cnt", i), count, tbl[i].cnt);
      if (tbl[i].mv) chk($sformatf("v%0d_md", i), u_if.m_data, tbl[i].md);
    end

    // Both streams busy: port alternates write/read
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1);
      chk($sformatf("alt%0d_en", i), rf_enable, 1);
      chk($sformatf("alt%0d_wr", i), rf_wr, (i % 2 == 0) ? 1 : 0);
    end
    drain(16);

    // Fill to full with the consumer stalled, then wrap the write pointer
    n_acc = 0;
    for (int g = 0; g < 30; g++) begin
      step(1'b1, 8'(8'h30 + n_acc), 1'b0);
      if (!u_if.s_ready && count == 3'd4) break;
    end
    chk("full_cnt", count, 4);
    chk("full_srdy", u_if.s_ready, 0);
    chk("full_acc", n_acc, 6);
    chk("wrap_addr", acc_addr[4], acc_addr[0]);
    step(1'b0, '0, 1'b1);
    for (int g = 0; g < 10; g++) begin
      step(1'b1, 8'h55, 1'b0);
      if (n_acc == 7) break;
    end
    chk("w55_acc", n_acc, 7);
    drain(20);
    chk("wrap_last", last_pop, 8'h55);

    // Consumer stalled with 5 entries: only two reads may issue
    fill5(8'h60);
    drain(20);

    // Reset while count=3 and the output buffer is full
    fill5(8'h90);
    @(negedge clk);
    reset_n      = 1'b0;
    u_if.s_valid = 1'b1;
    u_if.s_data  = 8'hEE;
    #1;
    chk("mid_rst_mv", u_if.m_valid, 0);
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_en", rf_enable, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n      = 1'b1;
    u_if.s_valid = 1'b0;
    sb_q.delete();
    exp_wp = '0;
    step(1'b1, 8'h77, 1'b0);
    chk("post_rst_first", {rf_enable, rf_wr}, 2'b11);
    drain(10);
    chk("post_rst_data", last_pop, 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
